// File: rtl/keypad_entry_ctrl_if.sv
// Bundle of keypad, arithmetic-unit and display signals around keypad_entry_ctrl.
// master: keypad plus arithmetic unit side; slave: the entry controller.
interface keypad_entry_ctrl_if #(
  parameter int DIGITS = 6
);
  localparam int DW = 4*DIGITS;

  logic [3:0]    key_value;
  logic          flag;
  logic [DW-1:0] num_result;
  logic          result_err;
  logic          calc_done;

  logic [DW-1:0] num_reg1;
  logic [DW-1:0] num_reg2;
  logic [3:0]    opcode;
  logic          calc_req;
  logic          err;
  logic [DW-1:0] num_out;

  modport master (
    output key_value, flag, num_result, result_err, calc_done,
    input  num_reg1, num_reg2, opcode, calc_req, err, num_out
  );

  modport slave (
    input  key_value, flag, num_result, result_err, calc_done,
    output num_reg1, num_reg2, opcode, calc_req, err, num_out
  );
endinterface

// File: rtl/keypad_entry_ctrl.sv
// Calculator keypad entry controller: collects two BCD operands and an
// operator, hands them to an external arithmetic unit, and chains results.
module keypad_entry_ctrl #(
  parameter int DIGITS = 6
) (
  input  logic              CLK_1K,
  input  logic              RSTN,
  keypad_entry_ctrl_if.slave bus
);
  localparam int DW = 4*DIGITS;
  localparam logic [3:0] FULL = 4'(DIGITS);

  typedef enum logic [2:0] {
    S_A,
    S_OP,
    S_B,
    S_CALC,
    S_RES,
    S_ERR
  } state_t;

  state_t        state_q;
  logic [DW-1:0] num1_q, num2_q;
  logic [3:0]    opcode_q, pend_q;
  logic [3:0]    cnt1_q, cnt2_q;
  logic          calc_req_q, err_q;

  logic [DW-1:0] num1_d, num2_d, fresh_d;
  logic [3:0]    cnt1_d, cnt2_d, fresh_cnt_d;
  logic          key_digit, key_op, key_eq, key_clr;

  // Shift a digit in at the right; a full operand or a leading zero leaves it as is.
  function automatic logic [DW-1:0] shift_num(input logic [DW-1:0] r,
                                              input logic [3:0] c,
                                              input logic [3:0] d);
    if (c == FULL || (c == 4'd0 && d == 4'd0))
      return r;
    return (r << 4) | DW'(d);
  endfunction

  // Digit count companion of shift_num: leading zeros are not counted.
  function automatic logic [3:0] shift_cnt(input logic [3:0] c,
                                           input logic [3:0] d);
    if (c == FULL)
      return c;
    if (c == 4'd0 && d == 4'd0)
      return 4'd0;
    return c + 4'd1;
  endfunction

  // Key decode and the candidate operand values for a digit press.
  always_comb begin
    key_digit   = bus.flag && (bus.key_value <= 4'd9);
    key_op      = bus.flag && (bus.key_value >= 4'hA) && (bus.key_value <= 4'hD);
    key_eq      = bus.flag && (bus.key_value == 4'hE);
    key_clr     = bus.flag && (bus.key_value == 4'hF);
    num1_d      = shift_num(num1_q, cnt1_q, bus.key_value);
    cnt1_d      = shift_cnt(cnt1_q, bus.key_value);
    num2_d      = shift_num(num2_q, cnt2_q, bus.key_value);
    cnt2_d      = shift_cnt(cnt2_q, bus.key_value);
    fresh_d     = shift_num('0, 4'd0, bus.key_value);
    fresh_cnt_d = shift_cnt(4'd0, bus.key_value);
  end

  // Entry FSM with its operand registers and registered request/error flags.
  always_ff @(posedge CLK_1K or negedge RSTN) begin
    if (!RSTN) begin
      state_q    <= S_A;
      num1_q     <= '0;
      num2_q     <= '0;
      opcode_q   <= 4'd0;
      pend_q     <= 4'd0;
      cnt1_q     <= 4'd0;
      cnt2_q     <= 4'd0;
      calc_req_q <= 1'b0;
      err_q      <= 1'b0;
    end else if (key_clr && state_q != S_B) begin
      // All clear; in CALC this also beats a simultaneous calc_done.
      state_q    <= S_A;
      num1_q     <= '0;
      num2_q     <= '0;
      opcode_q   <= 4'd0;
      pend_q     <= 4'd0;
      cnt1_q     <= 4'd0;
      cnt2_q     <= 4'd0;
      calc_req_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        S_A: begin
          if (key_digit) begin
            num1_q <= num1_d;
            cnt1_q <= cnt1_d;
          end else if (key_op) begin
            opcode_q <= bus.key_value;
            state_q  <= S_OP;
          end
        end
        S_OP: begin
          if (key_op) begin
            opcode_q <= bus.key_value;
          end else if (key_digit) begin
            num2_q  <= fresh_d;
            cnt2_q  <= fresh_cnt_d;
            state_q <= S_B;
          end
        end
        S_B: begin
          if (key_clr) begin
            // Clear entry: drop operand B only, keep the operator.
            num2_q  <= '0;
            cnt2_q  <= 4'd0;
            state_q <= S_OP;
          end else if (key_digit) begin
            num2_q <= num2_d;
            cnt2_q <= cnt2_d;
          end else if (key_eq) begin
            pend_q     <= 4'd0;
            calc_req_q <= 1'b1;
            state_q    <= S_CALC;
          end else if (key_op) begin
            // Chained operator: compute now, apply the new operator afterwards.
            pend_q     <= bus.key_value;
            calc_req_q <= 1'b1;
            state_q    <= S_CALC;
          end
        end
        S_CALC: begin
          if (bus.calc_done) begin
            calc_req_q <= 1'b0;
            num2_q     <= '0;
            cnt2_q     <= 4'd0;
            if (bus.result_err) begin
              num1_q  <= '0;
              cnt1_q  <= 4'd0;
              err_q   <= 1'b1;
              state_q <= S_ERR;
            end else begin
              num1_q <= bus.num_result;
              cnt1_q <= FULL;
              if (pend_q != 4'd0) begin
                opcode_q <= pend_q;
                pend_q   <= 4'd0;
                state_q  <= S_OP;
              end else begin
                state_q <= S_RES;
              end
            end
          end
        end
        S_RES: begin
          if (key_digit) begin
            num1_q   <= fresh_d;
            cnt1_q   <= fresh_cnt_d;
            opcode_q <= 4'd0;
            state_q  <= S_A;
          end else if (key_op) begin
            opcode_q <= bus.key_value;
            state_q  <= S_OP;
          end
        end
        S_ERR: begin
          err_q <= 1'b1;
        end
        default: state_q <= S_A;
      endcase
    end
  end

  assign bus.num_reg1 = num1_q;
  assign bus.num_reg2 = num2_q;
  assign bus.opcode   = opcode_q;
  assign bus.calc_req = calc_req_q;
  assign bus.err      = err_q;
  assign bus.num_out  = (state_q == S_B || state_q == S_CALC) ? num2_q : num1_q;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Testbench for keypad_entry_ctrl: per-cycle vector table plus reset sequences.
module tb_keypad_entry_ctrl;
  localparam int DIGITS = 6;
  localparam int DW = 4*DIGITS;

  logic CLK_1K = 1'b0;
  logic RSTN;

  keypad_entry_ctrl_if #(.DIGITS(DIGITS)) bus ();
  keypad_entry_ctrl #(.DIGITS(DIGITS)) dut (.CLK_1K(CLK_1K), .RSTN(RSTN), .bus(bus));

  always #5 CLK_1K = ~CLK_1K;

  typedef struct {
    string         name;
    int            key;   // -1: no key strobe
    logic          done;
    logic [DW-1:0] res;
    logic          rerr;
    logic [DW-1:0] e1, e2, eout;
    logic [3:0]    eop;
    logic          ereq, eerr;
  } vec_t;

  typedef struct {
    string         name;
    logic [DW-1:0] e1, e2, eout;
    logic [3:0]    eop;
    logic          ereq, eerr;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  function automatic vec_t mk(string n, int k, int d, int r, int re,
                              int e1, int e2, int op, int rq, int er, int eo);
    vec_t v;
    v.name = n; v.key = k; v.done = (d != 0); v.res = DW'(r); v.rerr = (re != 0);
    v.e1 = DW'(e1); v.e2 = DW'(e2); v.eop = 4'(op);
    v.ereq = (rq != 0); v.eerr = (er != 0); v.eout = DW'(eo);
    return v;
  endfunction

  function automatic vec_t K(string n, int k, int e1, int e2, int op, int rq, int er, int eo);
    return mk(n, k, 0, 0, 0, e1, e2, op, rq, er, eo);
  endfunction

  task automatic cmp(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic push_exp(input string n, input logic [DW-1:0] e1, input logic [DW-1:0] e2,
                          input logic [3:0] op, input logic rq, input logic er,
                          input logic [DW-1:0] eo);
    exp_t e;
    e.name = n; e.e1 = e1; e.e2 = e2; e.eop = op; e.ereq = rq; e.eerr = er; e.eout = eo;
    sb.push_back(e);
  endtask

  task automatic check_front();
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty actual=0 required=1");
    end else begin
      checks--;
      e = sb.pop_front();
      cmp({e.name, ".num_reg1"}, bus.num_reg1, e.e1);
      cmp({e.name, ".num_reg2"}, bus.num_reg2, e.e2);
      cmp({e.name, ".opcode"}, DW'(bus.opcode), DW'(e.eop));
      cmp({e.name, ".calc_req"}, DW'(bus.calc_req), DW'(e.ereq));
      cmp({e.name, ".err"}, DW'(bus.err), DW'(e.eerr));
      cmp({e.name, ".num_out"}, bus.num_out, e.eout);
    end
  endtask

  // One cycle: drive on the falling edge, compare just after the rising edge.
  task automatic apply(input vec_t v);
    @(negedge CLK_1K);
    bus.flag       = (v.key >= 0);
    bus.key_value  = 4'(v.key);
    bus.calc_done  = v.done;
    bus.num_result = v.res;
    bus.result_err = v.rerr;
    push_exp(v.name, v.e1, v.e2, v.eop, v.ereq, v.eerr, v.eout);
    @(posedge CLK_1K);
    #1;
    check_front();
  endtask

  initial begin
    // Basic entry and calculation
    tbl.push_back(K("a1", 1, 'h1, 0, 0, 0, 0, 'h1));
    tbl.push_back(K("a12", 2, 'h12, 0, 0, 0, 0, 'h12));
    tbl.push_back(K("a123", 3, 'h123, 0, 0, 0, 0, 'h123));
    tbl.push_back(K("opA", 10, 'h123, 0, 10, 0, 0, 'h123));
    tbl.push_back(K("b4", 4, 'h123, 'h4, 10, 0, 0, 'h4));
    tbl.push_back(K("b45", 5, 'h123, 'h45, 10, 0, 0, 'h45));
    tbl.push_back(K("eq", 14, 'h123, 'h45, 10, 1, 0, 'h45));
    tbl.push_back(K("calc_idle", -1, 'h123, 'h45, 10, 1, 0, 'h45));
    tbl.push_back(K("calc_key7", 7, 'h123, 'h45, 10, 1, 0, 'h45));
    tbl.push_back(K("calc_keyB", 11, 'h123, 'h45, 10, 1, 0, 'h45));
    tbl.push_back(mk("done", -1, 1, 'h168, 0, 'h168, 0, 10, 0, 0, 'h168));
    tbl.push_back(K("res_idle", -1, 'h168, 0, 10, 0, 0, 'h168));
    tbl.push_back(K("res_eq", 14, 'h168, 0, 10, 0, 0, 'h168));
    tbl.push_back(K("res_dig9", 9, 'h9, 0, 0, 0, 0, 'h9));
    tbl.push_back(K("clr1", 15, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("done_in_A", -1, 1, 'h777, 0, 0, 0, 0, 0, 0, 0));
    // Leading zeros and the digit limit on operand A
    tbl.push_back(K("z0", 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(K("z00", 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(K("l1", 1, 'h1, 0, 0, 0, 0, 'h1));
    tbl.push_back(K("l2", 2, 'h12, 0, 0, 0, 0, 'h12));
    tbl.push_back(K("noflag", -1, 'h12, 0, 0, 0, 0, 'h12));
    tbl.push_back(K("l3", 3, 'h123, 0, 0, 0, 0, 'h123));
    tbl.push_back(K("l4", 4, 'h1234, 0, 0, 0, 0, 'h1234));
    tbl.push_back(K("l5", 5, 'h12345, 0, 0, 0, 0, 'h12345));
    tbl.push_back(K("l6", 6, 'h123456, 0, 0, 0, 0, 'h123456));
    tbl.push_back(K("l7_ignored", 7, 'h123456, 0, 0, 0, 0, 'h123456));
    tbl.push_back(K("clr2", 15, 0, 0, 0, 0, 0, 0));
    // Operator replacement, chaining and clear entry
    tbl.push_back(K("c2", 2, 'h2, 0, 0, 0, 0, 'h2));
    tbl.push_back(K("cA", 10, 'h2, 0, 10, 0, 0, 'h2));
    tbl.push_back(K("cC", 12, 'h2, 0, 12, 0, 0, 'h2));
    tbl.push_back(K("c3", 3, 'h2, 'h3, 12, 0, 0, 'h3));
    tbl.push_back(K("cB_chain", 11, 'h2, 'h3, 12, 1, 0, 'h3));
    tbl.push_back(mk("c_done", -1, 1, 'h5, 0, 'h5, 0, 11, 0, 0, 'h5));
    tbl.push_back(K("c4", 4, 'h5, 'h4, 11, 0, 0, 'h4));
    tbl.push_back(K("c_ce", 15, 'h5, 0, 11, 0, 0, 'h5));
    tbl.push_back(K("c6", 6, 'h5, 'h6, 11, 0, 0, 'h6));
    tbl.push_back(K("c_ce2", 15, 'h5, 0, 11, 0, 0, 'h5));
    tbl.push_back(K("c_ac", 15, 0, 0, 0, 0, 0, 0));
    // Arithmetic error and the locked error state
    tbl.push_back(K("e9", 9, 'h9, 0, 0, 0, 0, 'h9));
    tbl.push_back(K("eD", 13, 'h9, 0, 13, 0, 0, 'h9));
    tbl.push_back(K("e0", 0, 'h9, 0, 13, 0, 0, 0));
    tbl.push_back(K("eE", 14, 'h9, 0, 13, 1, 0, 0));
    tbl.push_back(mk("e_done", -1, 1, 'h999, 1, 0, 0, 13, 0, 1, 0));
    tbl.push_back(K("err_5", 5, 0, 0, 13, 0, 1, 0));
    tbl.push_back(K("err_E", 14, 0, 0, 13, 0, 1, 0));
    tbl.push_back(K("err_F", 15, 0, 0, 0, 0, 0, 0));
    // Operand B digit limit, result then operator from RES
    tbl.push_back(K("m1", 1, 'h1, 0, 0, 0, 0, 'h1));
    tbl.push_back(K("mA", 10, 'h1, 0, 10, 0, 0, 'h1));
    tbl.push_back(K("m9a", 9, 'h1, 'h9, 10, 0, 0, 'h9));
    tbl.push_back(K("m9b", 9, 'h1, 'h99, 10, 0, 0, 'h99));
    tbl.push_back(K("m9c", 9, 'h1, 'h999, 10, 0, 0, 'h999));
    tbl.push_back(K("m9d", 9, 'h1, 'h9999, 10, 0, 0, 'h9999));
    tbl.push_back(K("m9e", 9, 'h1, 'h99999, 10, 0, 0, 'h99999));
    tbl.push_back(K("m9f", 9, 'h1, 'h999999, 10, 0, 0, 'h999999));
    tbl.push_back(K("m8_ignored", 8, 'h1, 'h999999, 10, 0, 0, 'h999999));
    tbl.push_back(K("mE", 14, 'h1, 'h999999, 10, 1, 0, 'h999999));
    tbl.push_back(mk("m_done", -1, 1, 'h2, 0, 'h2, 0, 10, 0, 0, 'h2));
    tbl.push_back(K("m_resB", 11, 'h2, 0, 11, 0, 0, 'h2));
    tbl.push_back(K("m_ac", 15, 0, 0, 0, 0, 0, 0));
    // Clear and calc_done in the same CALC cycle
    tbl.push_back(K("f1", 1, 'h1, 0, 0, 0, 0, 'h1));
    tbl.push_back(K("fA", 10, 'h1, 0, 10, 0, 0, 'h1));
    tbl.push_back(K("f2", 2, 'h1, 'h2, 10, 0, 0, 'h2));
    tbl.push_back(K("fE", 14, 'h1, 'h2, 10, 1, 0, 'h2));
    tbl.push_back(mk("f_clr_done", 15, 1, 'h3, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(K("f_after", -1, 0, 0, 0, 0, 0, 0));

    bus.flag = 1'b0; bus.key_value = 4'd0; bus.calc_done = 1'b0;
    bus.num_result = '0; bus.result_err = 1'b0;
    RSTN = 1'b0;
    #2;
    push_exp("reset", '0, '0, 4'd0, 1'b0, 1'b0, '0);
    check_front();
    @(negedge CLK_1K);
    RSTN = 1'b1;

    foreach (tbl[i]) apply(tbl[i]);

    // Asynchronous reset in the middle of a calculation
    apply(K("r8", 8, 'h8, 0, 0, 0, 0, 'h8));
    apply(K("rA", 10, 'h8, 0, 10, 0, 0, 'h8));
    apply(K("r1", 1, 'h8, 'h1, 10, 0, 0, 'h1));
    apply(K("rE", 14, 'h8, 'h1, 10, 1, 0, 'h1));
    @(negedge CLK_1K);
    bus.flag = 1'b0;
    #2;
    RSTN = 1'b0;
    #1;
    push_exp("async_rst", '0, '0, 4'd0, 1'b0, 1'b0, '0);
    check_front();
    @(negedge CLK_1K);
    RSTN = 1'b1;
    apply(K("post_rst7", 7, 'h7, 0, 0, 0, 0, 'h7));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/keypad_entry_ctrl.md
KEYPAD_ENTRY_CTRL -- requirements
Module: keypad_entry_ctrl

Interface
REQ-001 SHALL have parameter DIGITS, default 6: number of BCD digits per operand, legal range 1..8.
REQ-002 SHALL have derived localparam DW = 4*DIGITS: operand/result width in bits.
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 CLK_1K  in  1  system clock; all state changes on its rising edge.
REQ-005 RSTN  in  1  asynchronous active-low reset.
REQ-006 key_value  in  4  key code: 0-9 digit, A-D operator, E equals, F clear.
REQ-007 flag  in  1  one-cycle key-valid strobe; key_value is ignored when flag=0.
REQ-008 num_result  in  DW  BCD result from the arithmetic unit, valid when calc_done=1.
REQ-009 result_err  in  1  error qualifier for num_result, valid when calc_done=1.
REQ-010 calc_done  in  1  arithmetic-unit completion, sampled only in CALC.
REQ-011 num_reg1  out  DW  operand A / running result, BCD.
REQ-012 num_reg2  out  DW  operand B, BCD.
REQ-013 opcode  out  4  latched operator (A-D), 0 when none.
REQ-014 calc_req  out  1  request to the arithmetic unit, registered.
REQ-015 err  out  1  error indicator, registered.
REQ-016 num_out  out  DW  display value, combinational: num_reg2 in B and CALC, num_reg1 otherwise.

Function
REQ-017 SHALL implement states A (enter operand A), OP (operator held), B (enter operand B), CALC, RES and ERR.
REQ-018 SHALL track a digit count per operand; a digit d shifts in as {reg[DW-5:0],d}.
- A digit is ignored when the count equals DIGITS.
- A 0 digit with count=0 leaves the register 0 and the count 0.
- Any other digit increments the count.
REQ-019 In A: a digit updates num_reg1; an operator sets opcode and goes to OP; E is ignored.
REQ-020 In OP: an operator replaces opcode.
- A digit loads num_reg2={0,d}, sets count2 (0 if d=0, else 1) and goes to B.
- E is ignored.
REQ-021 In B: a digit updates num_reg2.
- E goes to CALC with no pending operator.
- An operator stores it as pending and goes to CALC (chaining).
REQ-022 In CALC: calc_req=1 on every cycle; num_reg1, num_reg2 and opcode SHALL NOT change while calc_req=1.
REQ-023 In CALC, on calc_done=1 with result_err=0:
- num_reg1<=num_result, num_reg2<=0, count1<=DIGITS, calc_req<=0.
- Pending operator: opcode<=pending, go to OP.
- No pending operator: go to RES.
REQ-024 In CALC, on calc_done=1 with result_err=1: num_reg1<=0, num_reg2<=0, err<=1, calc_req<=0, go to ERR.
REQ-025 The latency from calc_done sampled high to calc_req low SHALL be one cycle; calc_req SHALL NOT reassert within the same transaction.
REQ-026 In CALC, keys other than F SHALL be ignored.
REQ-027 In RES:
- A digit sets num_reg1={0,d}, count1 per REQ-018, opcode<=0, and goes to A.
- An operator sets opcode and goes to OP.
- E is ignored.
REQ-028 In ERR, all keys except F SHALL be ignored, and err SHALL hold 1.
REQ-029 F in B (clear entry) SHALL set num_reg2=0, count2=0 and go to OP; opcode is kept.
REQ-030 F in any other state (all clear) SHALL zero num_reg1, num_reg2, opcode, the pending operator, both counts, calc_req and err, then go to A.
REQ-031 F with calc_done in the same CALC cycle: F wins, and the result SHALL be discarded.

Reset
REQ-032 RSTN=0 SHALL immediately, asynchronously force:
- state A;
- num_reg1, num_reg2, opcode, calc_req and err to 0;
- both counts and the pending operator to 0.
REQ-033 Reset mid-CALC SHALL drop calc_req asynchronously; the first key after release SHALL be processed from A.

Verification
REQ-034 DIGITS=6; keys 1,2,3,A,4,5,E; calc_done with num_result=0x000168 -> num_reg1=0x000123, opcode=A, num_reg2=0x000045, calc_req high until one cycle after done, then num_reg1=0x000168, num_out=0x000168, state RES.
REQ-035 Keys 0,0,1,2,3,4,5,6,7 -> num_reg1=0x123456; the 7 is ignored.
REQ-036 Keys 2,A,C,3,B; done with num_result=0x000005 -> opcode=C before B; after done, num_reg1=0x000005, num_reg2=0, opcode=B, state OP; then keys 4,F -> num_reg2=0, state OP.
REQ-037 Keys 9,D,0,E; done with result_err=1 -> err=1, num_out=0; keys 5 and E are ignored; F -> err=0, all registers 0, state A.
REQ-038 In CALC, F and calc_done in the same cycle -> calc_req=0 next cycle and all registers 0; num_result is not loaded.
REQ-039 RSTN pulsed low mid-CALC -> all outputs 0 without a clock edge; after release, key 7 -> num_reg1=0x000007.
